ula_sequenciador_nibble: RTL and testbench

//  Upstream operand sequencer for the 4-bit carry-lookahead ALU (ula).

---
 rtl/ula_pkg.sv | 29 ++
 rtl/ula_sequenciador_nibble.sv | 149 ++++++++++++++
 tb/tb_ula_sequenciador_nibble.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for the 4-bit ALU and its nibble sequencer.
package ula_pkg;

  localparam int SLICE_W = 4;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NOT  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // ADD and SUB both use the ALU adder and chain carry between slices.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // 11x opcodes produce a zero result without using the ALU.
  function automatic logic is_zero_op(input logic [2:0] op);
    return op[2:1] == 2'b11;
  endfunction

endpackage

// File: rtl/ula_sequenciador_nibble.sv
// Operand sequencer: splits one wide command into 4-bit slices for the
// external combinational ALU, chains the carry, and reassembles the result.
module ula_sequenciador_nibble
  import ula_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = SLICE_W * NIBBLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_a,
  input  logic [W-1:0]       in_b,
  input  logic [2:0]         in_op,
  input  logic               in_cin,
  output logic [SLICE_W-1:0] ula_a,
  output logic [SLICE_W-1:0] ula_b,
  output logic [2:0]         ula_seletor,
  output logic               ula_carry_in,
  input  logic [SLICE_W-1:0] ula_resultado,
  input  logic               ula_carry_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_result,
  output logic               out_carry,
  output logic               out_zero
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, b_q, acc_q, acc_next, result_q;
  logic [2:0]         op_q;
  logic               carry_q, out_carry_q, out_zero_q;
  logic [IDX_W-1:0]   idx_q;
  logic [SLICE_W-1:0] slice_a, slice_b, slice_res;
  logic               last_slice;

  assign last_slice = (idx_q == IDX_W'(NIBBLES - 1));
  assign slice_res  = is_zero_op(op_q) ? '0 : ula_resultado;

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign out_result = result_q;
  assign out_carry  = out_carry_q;
  assign out_zero   = out_zero_q;

  // Select the operand slices addressed by the current index.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    slice_a = '0;
    slice_b = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        slice_a = a_q[i*SLICE_W +: SLICE_W];
        slice_b = b_q[i*SLICE_W +: SLICE_W];
      end
    end
  end

  // Merge the current ALU slice into the accumulated result.
  always_comb begin
    acc_next = acc_q;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) acc_next[i*SLICE_W +: SLICE_W] = slice_res;
    end
  end

  // Drive the ALU only while running; SUB is A + ~B + 1 on the adder.
  always_comb begin
    ula_a        = '0;
    ula_b        = '0;
    ula_seletor  = '0;
    ula_carry_in = 1'b0;
    if (state_q == ST_RUN) begin
      unique case (op_q)
        OP_ADD: begin
          ula_a = slice_a; ula_b = slice_b;  ula_seletor = OP_ADD; ula_carry_in = carry_q;
        end
        OP_SUB: begin
          ula_a = slice_a; ula_b = ~slice_b; ula_seletor = OP_ADD; ula_carry_in = carry_q;
        end
        OP_AND, OP_OR, OP_NOT, OP_NAND: begin
          ula_a = slice_a; ula_b = slice_b;  ula_seletor = op_q;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic: IDLE -> RUN -> DONE -> IDLE; in_valid ignored outside IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (in_valid)   state_d = ST_RUN;
      ST_RUN:  if (last_slice) state_d = ST_DONE;
      ST_DONE: if (out_ready)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Datapath: latch command, step slices, publish the final result on entering DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the datapath is reset too, so an aborted command can never leak a partial result.
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      out_carry_q <= 1'b0;
      out_zero_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (in_valid) begin
          a_q     <= in_a;
          b_q     <= in_b;
          op_q    <= in_op;
          idx_q   <= '0;
          acc_q   <= '0;
          carry_q <= (in_op == OP_ADD) ? in_cin : (in_op == OP_SUB);
        end
        ST_RUN: begin
          acc_q <= acc_next;
          if (is_arith(op_q)) carry_q <= ula_carry_out;
          if (!last_slice) begin
            idx_q <= idx_q + IDX_W'(1);
          end else begin
            result_q    <= acc_next;
            out_carry_q <= is_arith(op_q) ? ula_carry_out : 1'b0;
            out_zero_q  <= (acc_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_sequenciador_nibble.sv
// Bench for the nibble sequencer with a behavioural 4-bit ALU beside it.
module tb_ula_sequenciador_nibble;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  typedef struct packed {
    logic [W-1:0] result;
    logic         carry;
    logic         zero;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [2:0]   in_op = '0;
  logic         in_cin = 1'b0;
  logic [3:0]   ula_a, ula_b, ula_resultado;
  logic [2:0]   ula_seletor;
  logic         ula_carry_in, ula_carry_out;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_result;
  logic         out_carry, out_zero;

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];

  ula_sequenciador_nibble #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_cin(in_cin),
    .ula_a(ula_a), .ula_b(ula_b), .ula_seletor(ula_seletor), .ula_carry_in(ula_carry_in),
    .ula_resultado(ula_resultado), .ula_carry_out(ula_carry_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carry(out_carry), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  // Behavioural 4-bit ALU.
  always_comb begin
    ula_resultado = '0;
    ula_carry_out = 1'b0;
    case (ula_seletor)
      3'b000: ula_resultado = ula_a & ula_b;
      3'b001: ula_resultado = ula_a | ula_b;
      3'b010: ula_resultado = ~ula_a;
      3'b011: ula_resultado = ~(ula_a & ula_b);
      3'b100: {ula_carry_out, ula_resultado} = {1'b0, ula_a} + {1'b0, ula_b} + 5'(ula_carry_in);
      default: ;
    endcase
  end

  // Wide reference model of one command.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] op, input logic cin);
    exp_t     e;
    logic [W:0] s;
    e = '0;
    case (op)
      3'b000: e.result = a & b;
      3'b001: e.result = a | b;
      3'b010: e.result = ~a;
      3'b011: e.result = ~(a & b);
      3'b100: begin s = {1'b0, a} + {1'b0, b} + (W+1)'(cin); e.result = s[W-1:0]; e.carry = s[W]; end
      3'b101: begin s = {1'b0, a} + {1'b0, ~b} + (W+1)'(1); e.result = s[W-1:0]; e.carry = s[W]; end
      default: ;
    endcase
    e.zero = (e.result == '0);
    return e;
  endfunction

  // Present a command at the negedge and let it be accepted on the next posedge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2:0] op, input logic cin, input string name);
    @(negedge clk);
    in_a = a; in_b = b; in_op = op; in_cin = cin; in_valid = 1'b1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Issue one command, check latency and result, optionally hold backpressure, then retire it.
  task automatic run_cmd(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                         input logic cin, input int hold, input string name);
    exp_t e;
    int   n;
    exp_q.push_back(model(a, b, op, cin));
    send(a, b, op, cin, name);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1 n++;
    end
    e = exp_q.pop_front();
    total++;
    if (n != NIBBLES) begin
      bad++; $display("FAIL %s latency: got %0d want %0d", name, n, NIBBLES);
      if (out_valid !== 1'b1) return;
    end
    total++;
    if (out_result !== e.result) begin
      bad++; $display("FAIL %s result: got %h want %h", name, out_result, e.result);
    end
    total++;
    if (out_carry !== e.carry) begin
      bad++; $display("FAIL %s carry: got %b want %b", name, out_carry, e.carry);
    end
    total++;
    if (out_zero !== e.zero) begin
      bad++; $display("FAIL %s zero: got %b want %b", name, out_zero, e.zero);
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      in_a = ~a; in_b = b; in_op = 3'b001; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== e.result ||
          out_carry !== e.carry || out_zero !== e.zero) begin
        bad++;
        $display("FAIL %s hold%0d: got v=%b r=%b res=%h c=%b z=%b want v=1 r=0 res=%h c=%b z=%b",
                 name, k, out_valid, in_ready, out_result, out_carry, out_zero,
                 e.result, e.carry, e.zero);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL %s retire: got v=%b r=%b want v=0 r=1", name, out_valid, in_ready);
    end
  endtask

  task automatic check_reset_values(input string name);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== '0 || out_carry !== 1'b0 ||
        out_zero !== 1'b0 || ula_a !== '0 || ula_b !== '0 || ula_seletor !== '0 ||
        ula_carry_in !== 1'b0) begin
      bad++;
      $display("FAIL %s: got r=%b v=%b res=%h c=%b z=%b a=%h b=%h s=%b ci=%b want r=1 all others 0",
               name, in_ready, out_valid, out_result, out_carry, out_zero,
               ula_a, ula_b, ula_seletor, ula_carry_in);
    end
  endtask

  task automatic test_reset();
    #1 check_reset_values("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check_reset_values("after_reset_idle");
  endtask

  task automatic test_add();
    run_cmd(16'h00FF, 16'h0001, 3'b100, 1'b0, 0, "add_00ff_1");
    run_cmd(16'hFFFF, 16'h0001, 3'b100, 1'b0, 0, "add_ffff_1");
    run_cmd(16'h0000, 16'h0000, 3'b100, 1'b1, 0, "add_cin");
  endtask

  task automatic test_sub();
    run_cmd(16'h1234, 16'h0235, 3'b101, 1'b0, 0, "sub_1234_0235");
    run_cmd(16'h0001, 16'h0002, 3'b101, 1'b1, 0, "sub_borrow");
    run_cmd(16'h5A5A, 16'h5A5A, 3'b101, 1'b0, 0, "sub_equal");
  endtask

  task automatic test_logic();
    run_cmd(16'hF0F0, 16'h3C3C, 3'b000, 1'b1, 0, "and");
    run_cmd(16'hF0F0, 16'h3C3C, 3'b001, 1'b0, 0, "or");
    run_cmd(16'h00FF, 16'h1234, 3'b010, 1'b0, 0, "not");
    run_cmd(16'hF0F0, 16'h3C3C, 3'b011, 1'b1, 0, "nand");
    run_cmd(16'hFFFF, 16'hFFFF, 3'b110, 1'b1, 0, "op110");
    run_cmd(16'h1234, 16'h4321, 3'b111, 1'b0, 0, "op111");
  endtask

  task automatic test_backpressure();
    run_cmd(16'h0F0F, 16'h0101, 3'b100, 1'b1, 5, "backpressure");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      run_cmd(16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 0, $sformatf("b2b%0d", i));
    end
  endtask

  task automatic test_mid_reset();
    run_cmd(16'h1234, 16'h0235, 3'b101, 1'b0, 0, "pre_reset_sub");
    send(16'h7777, 16'h1111, 3'b100, 1'b1, "aborted_add");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values("mid_reset_async");
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd(16'h7777, 16'h1111, 3'b100, 1'b1, 0, "post_reset_add");
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
